// File: rtl/gray_counter_arbiter.sv
// Round-robin arbiter that serialises increment/decrement/write requests onto
// one shared gray counter, one operation in flight, with a completion report.
module gray_counter_arbiter #(
  parameter int width = 10,
  parameter int NREQ  = 4,
  parameter int WRAP  = 1,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req__ENA_i,
  input  logic [2*NREQ-1:0]     req_op_i,
  input  logic [NREQ*width-1:0] req_v_i,
  output logic [NREQ-1:0]       req__RDY_o,
  output logic                  cnt_increment__ENA_o,
  output logic                  cnt_decrement__ENA_o,
  output logic                  cnt_writeBin__ENA_o,
  output logic                  cnt_writeGray__ENA_o,
  output logic [width-1:0]      cnt_writeBin_v_o,
  output logic [width-1:0]      cnt_writeGray_v_o,
  input  logic [width-1:0]      cnt_readBin_i,
  output logic                  done__ENA_o,
  output logic [IDW-1:0]        done_id_o,
  output logic [width-1:0]      done_value_o,
  output logic                  done_err_o
);

  localparam int IW = IDW + 1;

  // state  | meaning
  // IDLE   | grant offered to first requester at/after rr pointer
  // ISSUE  | one strobe to the counter (none if saturated)
  // RESP   | done pulse with post-op counter value
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [1:0]       op_q, op_d;
  logic [width-1:0] v_q, v_d;
  logic             err_q, err_d;
  logic [IDW-1:0]   done_id_q;
  logic [width-1:0] done_val_q;
  logic             done_err_q;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             grant_vld;
  logic             sat_block;
  logic             done_ena;

  always_comb begin
    logic [IW-1:0] idx;
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_q} + IW'(k);
      if (idx >= IW'(NREQ)) idx = idx - IW'(NREQ);
      if (!grant_vld && req__ENA_i[idx[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = idx[IDW-1:0];
      end
    end
    if (grant_vld) grant[grant_id] = 1'b1;
  end

  // Saturating mode refuses to move past either end of the counter range.
  assign sat_block = (WRAP == 0) &&
                     ((op_q == 2'd0 && cnt_readBin_i == '1) ||
                      (op_q == 2'd1 && cnt_readBin_i == '0));

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      id_q       <= '0;
      op_q       <= '0;
      v_q        <= '0;
      err_q      <= 1'b0;
      done_id_q  <= '0;
      done_val_q <= '0;
      done_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      v_q     <= v_d;
      err_q   <= err_d;
      if (state_q == S_RESP) begin
        done_id_q  <= id_q;
        done_val_q <= cnt_readBin_i;
        done_err_q <= err_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    op_d    = op_q;
    v_d     = v_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          id_d    = grant_id;
          op_d    = req_op_i[2*grant_id +: 2];
          v_d     = req_v_i[grant_id*width +: width];
          rr_d    = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        err_d   = sat_block;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are masked while nRST is low so an abandoned op emits nothing.
  always_comb begin
    req__RDY_o           = '0;
    cnt_increment__ENA_o = 1'b0;
    cnt_decrement__ENA_o = 1'b0;
    cnt_writeBin__ENA_o  = 1'b0;
    cnt_writeGray__ENA_o = 1'b0;
    done_ena             = 1'b0;
    if (nRST) begin
      case (state_q)
        S_IDLE:  req__RDY_o = grant;
        S_ISSUE: begin
          if (!sat_block) begin
            case (op_q)
              2'd0:    cnt_increment__ENA_o = 1'b1;
              2'd1:    cnt_decrement__ENA_o = 1'b1;
              2'd2:    cnt_writeBin__ENA_o  = 1'b1;
              default: cnt_writeGray__ENA_o = 1'b1;
            endcase
          end
        end
        S_RESP:  done_ena = 1'b1;
        default: done_ena = 1'b0;
      endcase
    end
  end

  assign cnt_writeBin_v_o  = v_q;
  assign cnt_writeGray_v_o = v_q;
  assign done__ENA_o       = done_ena;
  assign done_id_o         = done_ena ? id_q          : done_id_q;
  assign done_value_o      = done_ena ? cnt_readBin_i : done_val_q;
  assign done_err_o        = done_ena ? err_q         : done_err_q;

endmodule

// File: tb/tb_gray_counter_arbiter.sv
// Bench for gray_counter_arbiter: saturating and wrapping instances share stimulus,
// each drives its own emulated counter; a transaction-level model predicts every cycle.
module tb_gray_counter_arbiter;

  localparam int W = 4;
  localparam int N = 4;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [N-1:0]     req_ena;
  logic [2*N-1:0]   req_op;
  logic [N*W-1:0]   req_v;
  logic [W-1:0]     cnt_rd [2];
  logic [N-1:0]     rdy    [2];
  logic             inc    [2];
  logic             dec    [2];
  logic             wb     [2];
  logic             wg     [2];
  logic [W-1:0]     wbv    [2];
  logic [W-1:0]     wgv    [2];
  logic             dena   [2];
  logic [1:0]       did    [2];
  logic [W-1:0]     dval   [2];
  logic             derr   [2];

  gray_counter_arbiter #(.width(W), .NREQ(N), .WRAP(0)) u_sat (
    .CLK(CLK), .nRST(nRST), .req__ENA_i(req_ena), .req_op_i(req_op), .req_v_i(req_v),
    .req__RDY_o(rdy[0]), .cnt_increment__ENA_o(inc[0]), .cnt_decrement__ENA_o(dec[0]),
    .cnt_writeBin__ENA_o(wb[0]), .cnt_writeGray__ENA_o(wg[0]),
    .cnt_writeBin_v_o(wbv[0]), .cnt_writeGray_v_o(wgv[0]), .cnt_readBin_i(cnt_rd[0]),
    .done__ENA_o(dena[0]), .done_id_o(did[0]), .done_value_o(dval[0]), .done_err_o(derr[0])
  );

  gray_counter_arbiter #(.width(W), .NREQ(N), .WRAP(1)) u_wrap (
    .CLK(CLK), .nRST(nRST), .req__ENA_i(req_ena), .req_op_i(req_op), .req_v_i(req_v),
    .req__RDY_o(rdy[1]), .cnt_increment__ENA_o(inc[1]), .cnt_decrement__ENA_o(dec[1]),
    .cnt_writeBin__ENA_o(wb[1]), .cnt_writeGray__ENA_o(wg[1]),
    .cnt_writeBin_v_o(wbv[1]), .cnt_writeGray_v_o(wgv[1]), .cnt_readBin_i(cnt_rd[1]),
    .done__ENA_o(dena[1]), .done_id_o(did[1]), .done_value_o(dval[1]), .done_err_o(derr[1])
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // reference model state
  int cyc, rr, free_at, acc_id;
  bit has_pend;
  int p_strobe_cyc, p_done_cyc, p_id, p_v;
  int p_kind [2];
  int p_val  [2];
  int p_err  [2];
  int mc     [2];
  int mc_before [2];
  int last_id;
  int last_val [2];
  int last_err [2];

  // observations of the last step, used by the directed sequences
  int obs_rdy, obs_nstrobe, obs_dena, obs_did;
  int obs_dval [2];
  int obs_derr [2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int g2b(input int g);
    int b;
    b = g & 8;
    for (int i = 2; i >= 0; i--) b |= (((b >> (i + 1)) ^ (g >> i)) & 1) << i;
    return b;
  endfunction

  // kind: 0 inc, 1 dec, 2 writeBin, 3 writeGray, 4 no strobe
  task automatic model_op(input int inst, input int op, input int v,
                          output int val, output int err, output int kind);
    int cur;
    cur = mc[inst];
    err = 0;
    case (op)
      0: begin
        kind = 0;
        val  = (cur + 1) % 16;
        if (cur == 15 && inst == 0) begin val = 15; err = 1; kind = 4; end
      end
      1: begin
        kind = 1;
        val  = (cur + 15) % 16;
        if (cur == 0 && inst == 0) begin val = 0; err = 1; kind = 4; end
      end
      2: begin kind = 2; val = v; end
      default: begin kind = 3; val = g2b(v); end
    endcase
  endtask

  task automatic step();
    int exp_rdy;
    int exp_kind [2];
    int exp_done;
    int idx;
    int nxt [2];
    @(negedge CLK);
    exp_rdy  = 0;
    exp_kind = '{4, 4};
    exp_done = 0;
    acc_id   = -1;
    if (!nRST) begin
      if (has_pend && p_strobe_cyc >= cyc) mc = mc_before;
      has_pend = 0;
      rr       = 0;
      free_at  = cyc + 1;
      last_id  = 0;
      last_val = '{0, 0};
      last_err = '{0, 0};
    end else begin
      if (has_pend && cyc == p_strobe_cyc) exp_kind = p_kind;
      if (has_pend && cyc == p_done_cyc) begin
        exp_done = 1;
        last_id  = p_id;
        last_val = p_val;
        last_err = p_err;
        has_pend = 0;
      end
      if (cyc >= free_at) begin
        for (int k = 0; k < N; k++) begin
          idx = (rr + k) % N;
          if (acc_id < 0 && req_ena[idx]) acc_id = idx;
        end
      end
      if (acc_id >= 0) begin
        exp_rdy      = 1 << acc_id;
        rr           = (acc_id + 1) % N;
        free_at      = cyc + 3;
        has_pend     = 1;
        p_strobe_cyc = cyc + 1;
        p_done_cyc   = cyc + 2;
        p_id         = acc_id;
        p_v          = int'(req_v[acc_id*W +: W]);
        for (int i = 0; i < 2; i++) begin
          mc_before[i] = mc[i];
          model_op(i, int'(req_op[2*acc_id +: 2]), p_v, p_val[i], p_err[i], p_kind[i]);
          mc[i] = p_val[i];
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk("grant", int'(rdy[i]), exp_rdy);
      chk("strobes", int'({inc[i], dec[i], wb[i], wg[i]}), (exp_kind[i] == 4) ? 0 : (8 >> exp_kind[i]));
      if (exp_kind[i] == 2) chk("writeBin_data", int'(wbv[i]), p_v);
      if (exp_kind[i] == 3) chk("writeGray_data", int'(wgv[i]), p_v);
      chk("done_ena", int'(dena[i]), exp_done);
      if (nRST) begin
        chk("done_id", int'(did[i]), last_id);
        chk("done_value", int'(dval[i]), last_val[i]);
        chk("done_err", int'(derr[i]), last_err[i]);
      end
      obs_dval[i] = int'(dval[i]);
      obs_derr[i] = int'(derr[i]);
      nxt[i] = int'(cnt_rd[i]);
      if (inc[i]) nxt[i] = (nxt[i] + 1) % 16;
      if (dec[i]) nxt[i] = (nxt[i] + 15) % 16;
      if (wb[i])  nxt[i] = int'(wbv[i]);
      if (wg[i])  nxt[i] = g2b(int'(wgv[i]));
    end
    obs_rdy     = int'(rdy[0]);
    obs_nstrobe = int'(inc[0]) + int'(dec[0]) + int'(wb[0]) + int'(wg[0]);
    obs_dena    = int'(dena[0]);
    obs_did     = int'(did[0]);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++) cnt_rd[i] = W'(nxt[i]);
    cyc++;
  endtask

  task automatic reset_dut();
    nRST    = 1'b0;
    req_ena = '0;
    step();
    step();
    nRST = 1'b1;
  endtask

  task automatic preset(input int v);
    for (int i = 0; i < 2; i++) begin
      cnt_rd[i] = W'(v);
      mc[i]     = v;
    end
  endtask

  typedef struct {
    int pre; int id; int op; int v;
    int val0; int err0; int val1; int err1;
  } vec_t;

  vec_t tbl [9];
  int   gidx [8];
  int   dv   [8];
  int   ng, nd, hits, saved;
  bit   act  [N];

  initial begin
    nRST = 1'b0; req_ena = '0; req_op = '0; req_v = '0;
    cnt_rd = '{4'd0, 4'd0};
    mc = '{0, 0}; mc_before = '{0, 0};
    cyc = 0; rr = 0; free_at = 0; has_pend = 0;
    last_id = 0; last_val = '{0, 0}; last_err = '{0, 0};

    tbl[0] = '{ 5, 0, 0,  0,  6, 0,  6, 0};
    tbl[1] = '{15, 1, 0,  0, 15, 1,  0, 0};
    tbl[2] = '{ 0, 2, 1,  0,  0, 1, 15, 0};
    tbl[3] = '{ 7, 3, 1,  0,  6, 0,  6, 0};
    tbl[4] = '{15, 2, 2,  9,  9, 0,  9, 0};
    tbl[5] = '{-1, 3, 3, 13,  9, 0,  9, 0};
    tbl[6] = '{ 0, 0, 2, 15, 15, 0, 15, 0};
    tbl[7] = '{14, 1, 0,  0, 15, 0, 15, 0};
    tbl[8] = '{ 0, 3, 3,  8, 15, 0, 15, 0};

    reset_dut();

    for (int t = 0; t < 9; t++) begin
      if (tbl[t].pre >= 0) preset(tbl[t].pre);
      req_ena = N'(1 << tbl[t].id);
      req_op[2*tbl[t].id +: 2] = 2'(tbl[t].op);
      req_v[tbl[t].id*W +: W]  = W'(tbl[t].v);
      step();
      chk("tbl_grant", obs_rdy, 1 << tbl[t].id);
      req_ena = '0;
      step();
      chk("tbl_strobe_count", obs_nstrobe, tbl[t].err0 ? 0 : 1);
      step();
      chk("tbl_done_ena", obs_dena, 1);
      chk("tbl_done_id", obs_did, tbl[t].id);
      chk("tbl_value_sat", obs_dval[0], tbl[t].val0);
      chk("tbl_err_sat", obs_derr[0], tbl[t].err0);
      chk("tbl_value_wrap", obs_dval[1], tbl[t].val1);
      chk("tbl_err_wrap", obs_derr[1], tbl[t].err1);
    end

    // all four requesters held: strict rotation every third cycle
    reset_dut();
    preset(0);
    req_op = '0;
    req_ena = '1;
    ng = 0; nd = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (obs_rdy != 0 && ng < 8) begin
        for (int b = 0; b < N; b++) if (obs_rdy == (1 << b)) gidx[ng] = b;
        ng++;
      end
      if (obs_dena != 0 && nd < 8) begin dv[nd] = obs_dval[0]; nd++; end
    end
    req_ena = '0;
    chk("rr_grant_count", ng, 5);
    chk("rr_done_count", nd, 5);
    for (int j = 0; j < 5; j++) begin
      chk("rr_order", gidx[j], j % N);
      chk("rr_value", dv[j], j + 1);
    end

    // reset while the op is in ISSUE: abandoned, pointer back to 0
    reset_dut();
    req_op = '0;
    req_ena = 4'b0010;
    step();
    chk("rst_first_grant", obs_rdy, 2);
    saved = int'(cnt_rd[0]);
    nRST = 1'b0;
    req_ena = 4'b0110;
    step();
    chk("rst_no_strobe", obs_nstrobe, 0);
    chk("rst_no_done", obs_dena, 0);
    chk("rst_cnt_hold", int'(cnt_rd[0]), saved);
    nRST = 1'b1;
    step();
    chk("rst_regrant_req1", obs_rdy, 2);
    req_ena = '0;
    step();
    step();
    chk("rst_done_ena", obs_dena, 1);
    chk("rst_done_id", obs_did, 1);

    // one-cycle pulse from req1 during RESP is dropped
    reset_dut();
    req_ena = 4'b0001;
    step();
    req_ena = '0;
    step();
    req_ena = 4'b0010;
    step();
    chk("pulse_rdy_in_resp", obs_rdy, 0);
    req_ena = '0;
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (obs_rdy != 0) hits++;
      if (obs_dena != 0) hits++;
    end
    chk("pulse_dropped", hits, 0);

    // randomized traffic with occasional drops and resets
    reset_dut();
    for (int r = 0; r < N; r++) act[r] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < N; r++) begin
        if (!act[r] && $urandom_range(3) == 0) begin
          act[r] = 1'b1;
          req_op[2*r +: 2] = 2'($urandom_range(3));
          req_v[r*W +: W]  = W'($urandom_range(15));
        end else if (act[r] && $urandom_range(39) == 0) begin
          act[r] = 1'b0;
        end
        req_ena[r] = act[r];
      end
      nRST = ($urandom_range(149) != 0);
      step();
      if (acc_id >= 0) act[acc_id] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_counter_arbiter.md
GRAY_COUNTER_ARBITER -- requirements
Module: gray_counter_arbiter

Interface
REQ-001 Parameter: width, 10, bit width of the shared gray counter and of all value buses.
REQ-002 Parameter: NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ).
REQ-003 Parameter: WRAP, 1, 1 = increment/decrement wrap modulo 2^width, 0 = saturate with error.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 nRST  input  1  reset, synchronous, active-low.
REQ-006 req__ENA  input  NREQ  per-requester request valid; held until accepted.
REQ-007 req$op  input  2*NREQ  per-requester opcode: 0 increment, 1 decrement, 2 writeBin, 3 writeGray.
REQ-008 req$v  input  NREQ*width  per-requester write value; ignored for ops 0/1.
REQ-009 req__RDY  output  NREQ  one-hot grant; request i is accepted in the cycle req__ENA[i] & req__RDY[i].
REQ-010 cnt_increment__ENA, cnt_decrement__ENA, cnt_writeBin__ENA, cnt_writeGray__ENA  output  1 each  strobes to the shared counter.
REQ-011 cnt_writeBin$v, cnt_writeGray$v  output  width each  write data to the shared counter.
REQ-012 cnt_readBin  input  width  binary value of the shared counter.
REQ-013 done__ENA  output  1  completion pulse; done$id  output  IDW  served requester; done$value  output  width  counter value after the op; done$err  output  1  op suppressed.

Function
REQ-014 FSM states IDLE, ISSUE, RESP; at most one operation in flight.
REQ-015 IDLE: req__RDY = one-hot of first asserted req__ENA searching from rr_ptr upward modulo NREQ, combinational; all zero if none asserted or state != IDLE.
REQ-016 On acceptance: latch id, op, value; rr_ptr <= (id+1) mod NREQ; go to ISSUE.
REQ-017 ISSUE: exactly one cnt_*__ENA asserted for exactly one cycle per latched op; write data driven from latched value; go to RESP.
REQ-018 WRAP=0: increment when cnt_readBin == 2^width-1, or decrement when cnt_readBin == 0, drives no strobe in ISSUE and sets latched err=1.
REQ-019 WRAP=1: increment from 2^width-1 yields 0, decrement from 0 yields 2^width-1; err=0.
REQ-020 RESP: done__ENA=1 for one cycle with done$id = latched id, done$value = cnt_readBin, done$err = latched err; go to IDLE.
REQ-021 Latency: acceptance cycle N -> strobe cycle N+1 -> done cycle N+2; next acceptance earliest N+3.
REQ-022 Writes never set err; writeGray value is passed through unconverted.
REQ-023 Requests deasserted before acceptance are dropped without a done; requester changes of op/v after acceptance have no effect.
REQ-024 done$id/value/err hold last values when done__ENA=0.
REQ-025 rr_ptr advances only on acceptance.

Reset
REQ-026 nRST=0 at a rising edge: state IDLE, rr_ptr 0, latched err 0, all cnt_*__ENA 0, done__ENA 0, done$id/value/err 0, req__RDY 0 during reset.
REQ-027 Reset during ISSUE or RESP abandons the op; no strobe or done is emitted after reset; the counter contents are not reset by this block.

Verification
REQ-028 width=4, counter=5, req0 increment -> req__RDY=0001 same cycle, cnt_increment__ENA at N+1, done__ENA at N+2 with id 0, value 6, err 0.
REQ-029 All four requesters held continuously with increment -> grants in order 0,1,2,3,0 every 3 cycles; done values 1,2,3,4,5 from counter 0.
REQ-030 WRAP=0, counter=15 (width 4), increment -> no strobe, done value 15, err 1; decrement at 0 -> value 0, err 1; WRAP=1 increment at 15 -> value 0, err 0.
REQ-031 req2 writeBin v=9, then req3 writeGray v=0b1101 -> done values 9 then 9 (gray 1101 = bin 1001), correct strobes only.
REQ-032 nRST=0 asserted in ISSUE cycle -> no strobe, no done; after release rr_ptr=0 and a pending req1 is granted before req2.
REQ-033 req1 pulses ENA one cycle while state=RESP -> never granted, no done for id 1.
